req_rsp_responder: RTL and testbench
====================================

// Module: req_rsp_responder
// PURPOSE
// - Target (responder) end of the single-outstanding valid/ready request/response interface.
// - Accepts read/write requests from an initiator and services them against an internal word store.
// - Returns one response per accepted request after a programmable access latency.
// - Used as the reusable endpoint model behind interface-based lint and regression designs.
// PARAMETERS
// - DW      32  data width in bits
// - AW      4   address width in bits (word address)
// - DEPTH   12  number of implemented words; must satisfy DEPTH <= 2**AW
// - LATENCY 2   access wait cycles between accept and response (0..15)
// PORTS
// - clk        in   1   single clock, rising edge
// - rst_n      in   1   asynchronous active-low reset
// - req_valid  in   1   request present
// - req_ready  out  1   responder can accept a request
// - req_write  in   1   1 = write, 0 = read
// - req_addr   in   AW  word address
// - req_wdata  in   DW  write data
// - rsp_valid  out  1   response present
// - rsp_ready  in   1   initiator accepts the response
// - rsp_rdata  out  DW  read data; 0 for writes
// - rsp_err    out  1   address error flag (only driven when RESP_ERR_EN is defined, else 0)
// - busy       out  1   request accepted and not yet retired
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; busy=0.
// - Reset also clears the wait counter and all store words to 0.
// - Reset mid-transaction drops the in-flight request; no response is produced for it.
// - FSM states: IDLE, WAIT, RESP.
// - IDLE: req_ready=1. Accept on req_valid&&req_ready; capture write, addr, wdata.
//   - On accept with LATENCY==0: go to RESP.
//   - On accept with LATENCY>0: load cnt=LATENCY-1 and go to WAIT.
// - WAIT: req_ready=0. cnt decrements each cycle; at cnt==0 go to RESP.
// - Store access (write commit or read sample) occurs on the WAIT->RESP or IDLE->RESP transition edge.
// - RESP: rsp_valid=1; rsp_rdata/rsp_err are stable while rsp_valid&&!rsp_ready.
//   - On rsp_ready: go to IDLE; rsp_valid=0 next cycle.
// - Total latency: accept edge to first rsp_valid cycle = LATENCY+1 cycles.
// - Throughput: at most one request per LATENCY+2 cycles. No back-to-back accept in the same cycle as response retire.
// - req_ready is a registered output equal to (state==IDLE).
// - busy = (state!=IDLE).
// - Reads return the stored word. Writes return rsp_rdata=0.
// - A write followed by a read of the same address returns the new data.
// - Address range rule: address is out of range when req_addr >= DEPTH.
// - Request fields are ignored while req_ready=0. The initiator must hold them stable until accept.
// CONFIGURATION
// - RESP_ERR_EN defined:
//   - Out-of-range reads return rsp_rdata=0 and rsp_err=1.
//   - Out-of-range writes are discarded with rsp_err=1.
//   - Timing is unchanged.
// - RESP_ERR_EN undefined:
//   - rsp_err is tied 0.
//   - The address is reduced modulo DEPTH (req_addr % DEPTH) and every access succeeds.
// TESTING
// - Reset: hold rst_n=0 for 3 cycles, release -> req_ready=1, rsp_valid=0, busy=0, read of addr 5 returns 0.
// - LATENCY=2: write 0xDEAD_BEEF to addr 3 at cycle t -> rsp_valid first high at t+3, rsp_rdata=0, rsp_err=0.
//   Then read addr 3 -> rsp_rdata=0xDEAD_BEEF.
// - Backpressure: read with rsp_ready=0 for 4 cycles -> rsp_valid, rsp_rdata held constant and req_ready=0.
//   Retire on the 5th cycle -> req_ready=1 the next cycle.
// - Range, DEPTH=12, RESP_ERR_EN defined: write 0x55 to addr 13 -> rsp_err=1; read addr 13 -> rdata=0, err=1.
//   Without RESP_ERR_EN: the write lands in addr 1; a read of addr 1 returns 0x55.
// - LATENCY=0: accept at cycle t -> rsp_valid at t+1.
//   With rsp_ready held 1, the next request is accepted at t+2.
// - Reset mid-WAIT: assert rst_n=0 during the WAIT state -> no response; the store is cleared; the bench sees req_ready=1 after release.

Source files
------------

// File: rtl/req_rsp_responder.sv
// Responder end of a single-outstanding valid/ready request/response link, backed by a word store.
// Define RESP_ERR_EN to flag out-of-range addresses with rsp_err instead of wrapping them modulo DEPTH.
module req_rsp_responder #(
    parameter int DW      = 32,
    parameter int AW      = 4,
    parameter int DEPTH   = 12,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
    localparam logic [3:0]    CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          req_ready_q, req_ready_d;
    logic [DW-1:0] rdata_q, rdata_d;
`ifdef RESP_ERR_EN
    logic          err_q, err_d;
`endif

    logic [DW-1:0] store_q [DEPTH];
    logic          store_we;

    // Access fields come straight from the request when the store is touched on the accept edge.
    logic          acc_write;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic [IW-1:0] acc_idx;
    logic          acc_oob;
    logic          access_en;

    always_comb begin
        acc_write = (state_q == ST_IDLE) ? req_write : write_q;
        acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
        acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
`ifdef RESP_ERR_EN
        acc_oob   = ({1'b0, acc_addr} >= DEPTH_W);
        acc_idx   = IW'(acc_addr);
`else
        acc_oob   = 1'b0;
        acc_idx   = IW'({1'b0, acc_addr} % DEPTH_W);
`endif
    end

    // State register and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rdata_q     <= '0;
`ifdef RESP_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rdata_q     <= rdata_d;
`ifdef RESP_ERR_EN
            err_q       <= err_d;
`endif
        end
    end

    // Next-state and datapath logic.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
`ifdef RESP_ERR_EN
        err_d    = err_q;
`endif
        store_we = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The store is touched exactly once per request, on the edge that enters RESP.
        access_en = (state_d == ST_RESP) && (state_q != ST_RESP);
        if (access_en) begin
            store_we = acc_write && !acc_oob;
            rdata_d  = (acc_write || acc_oob) ? '0 : store_q[acc_idx];
`ifdef RESP_ERR_EN
            err_d    = acc_oob;
`endif
        end

        req_ready_d = (state_d == ST_IDLE);
    end

    // NOTE: the store is reset because a reset must leave every word reading back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                store_q[i] <= '0;
            end
        end else if (store_we) begin
            store_q[acc_idx] <= acc_wdata;
        end
    end

    // Output logic.
    always_comb begin
        req_ready = req_ready_q;
        rsp_valid = (state_q == ST_RESP);
        busy      = (state_q != ST_IDLE);
        rsp_rdata = rdata_q;
`ifdef RESP_ERR_EN
        rsp_err   = err_q;
`else
        rsp_err   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_req_rsp_responder.sv
// Self-checking bench for req_rsp_responder: table-driven transactions through a scoreboard,
// plus hand-written backpressure, reset-in-WAIT and zero-latency sequences.
module tb_req_rsp_responder;

    localparam int DW = 32;
    localparam int AW = 4;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            hold;
    } vec_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;

    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, busy;
    logic [DW-1:0] rsp_rdata;

    logic          req_valid0, req_ready0, req_write0;
    logic [AW-1:0] req_addr0;
    logic [DW-1:0] req_wdata0;
    logic          rsp_valid0, rsp_ready0, rsp_err0, busy0;
    logic [DW-1:0] rsp_rdata0;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    req_rsp_responder #(.DW(DW), .AW(AW), .DEPTH(12), .LATENCY(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    req_rsp_responder #(.DW(DW), .AW(AW), .DEPTH(12), .LATENCY(0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid0),
        .req_ready (req_ready0),
        .req_write (req_write0),
        .req_addr  (req_addr0),
        .req_wdata (req_wdata0),
        .rsp_valid (rsp_valid0),
        .rsp_ready (rsp_ready0),
        .rsp_rdata (rsp_rdata0),
        .rsp_err   (rsp_err0),
        .busy      (busy0)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    function automatic vec_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic [DW-1:0] er, input logic ee, input int hold);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = d; v.exp_rdata = er; v.exp_err = ee; v.hold = hold;
        return v;
    endfunction

    // One full transaction on the LATENCY=2 instance; lat counts falling edges from accept to rsp_valid.
    task automatic send(input vec_t v, output int lat);
        exp_t          e;
        int            budget;
        logic [DW-1:0] first;
        @(negedge clk);
        req_valid = 1'b1; req_write = v.write; req_addr = v.addr; req_wdata = v.wdata;
        rsp_ready = 1'b0;
        budget = 0;
        while (!req_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            fail_timeout("accept");
            req_valid = 1'b0;
            lat = -1;
            return;
        end
        @(posedge clk);
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        exp_q.push_back(e);
        #1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 50);
        if (!rsp_valid) begin
            fail_timeout("rsp_valid");
            return;
        end
        first = rsp_rdata;
        for (int i = 0; i < v.hold; i++) begin
            check("bp_rsp_valid", DW'(rsp_valid), 1);
            check("bp_rdata_stable", rsp_rdata, first);
            check("bp_req_ready", DW'(req_ready), 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        if (exp_q.size() == 0) begin
            fail_timeout("scoreboard_empty");
        end else begin
            e = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", DW'(rsp_err), DW'(e.err));
        end
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("post_retire_req_ready", DW'(req_ready), 1);
        check("post_retire_rsp_valid", DW'(rsp_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic e_en;
`ifdef RESP_ERR_EN
        e_en = 1'b1;
`else
        e_en = 1'b0;
`endif
        vecs.push_back(mk(1'b0, 4'd5,  32'h0,        32'h0, 1'b0, 0));
        vecs.push_back(mk(1'b1, 4'd3,  32'hDEADBEEF, 32'h0, 1'b0, 0));
        vecs.push_back(mk(1'b0, 4'd3,  32'h0,        32'hDEADBEEF, 1'b0, 4));
        vecs.push_back(mk(1'b1, 4'd0,  32'h00001234, 32'h0, 1'b0, 0));
        vecs.push_back(mk(1'b0, 4'd0,  32'h0,        32'h00001234, 1'b0, 0));
        vecs.push_back(mk(1'b1, 4'd11, 32'hA5A5A5A5, 32'h0, 1'b0, 1));
        vecs.push_back(mk(1'b0, 4'd11, 32'h0,        32'hA5A5A5A5, 1'b0, 0));
        vecs.push_back(mk(1'b1, 4'd13, 32'h00000055, 32'h0, e_en, 0));
        vecs.push_back(mk(1'b0, 4'd13, 32'h0,        e_en ? 32'h0 : 32'h55, e_en, 0));
        vecs.push_back(mk(1'b0, 4'd1,  32'h0,        e_en ? 32'h0 : 32'h55, 1'b0, 0));
        vecs.push_back(mk(1'b0, 4'd15, 32'h0,        e_en ? 32'h0 : 32'hDEADBEEF, e_en, 0));

        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; rsp_ready0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("reset_req_ready", DW'(req_ready), 1);
        check("reset_rsp_valid", DW'(rsp_valid), 0);
        check("reset_busy", DW'(busy), 0);
        check("reset_rsp_err", DW'(rsp_err), 0);
        check("reset_rsp_rdata", rsp_rdata, 0);

        foreach (vecs[i]) begin
            send(vecs[i], lat);
            check("latency_l2", DW'(lat), 3);
        end

        // Reset while the request sits in WAIT: it must vanish and the store must clear.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd2; req_wdata = 32'h77;
        check("midwait_pre_ready", DW'(req_ready), 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("midwait_busy", DW'(busy), 1);
        check("midwait_req_ready", DW'(req_ready), 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midwait_no_rsp", DW'(rsp_valid), 0);
            check("midwait_ready_after", DW'(req_ready), 1);
        end
        send(mk(1'b0, 4'd3, 32'h0, 32'h0, 1'b0, 0), lat);
        send(mk(1'b0, 4'd2, 32'h0, 32'h0, 1'b0, 0), lat);

        // Zero-latency instance: response one cycle after accept, next accept two cycles after.
        @(negedge clk);
        req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 4'd4; req_wdata0 = 32'h99; rsp_ready0 = 1'b1;
        check("l0_ready", DW'(req_ready0), 1);
        @(negedge clk);
        check("l0_rsp_valid_t1", DW'(rsp_valid0), 1);
        check("l0_wr_rdata", rsp_rdata0, 0);
        check("l0_ready_t1", DW'(req_ready0), 0);
        req_write0 = 1'b0; req_wdata0 = '0;
        @(negedge clk);
        check("l0_rsp_valid_t2", DW'(rsp_valid0), 0);
        check("l0_ready_t2", DW'(req_ready0), 1);
        @(negedge clk);
        check("l0_rsp_valid_t3", DW'(rsp_valid0), 1);
        check("l0_rd_rdata", rsp_rdata0, 32'h99);
        req_valid0 = 1'b0;
        @(negedge clk);
        check("l0_retired", DW'(rsp_valid0), 0);
        rsp_ready0 = 1'b0;

        check("scoreboard_drained", DW'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
